execute_mc: RTL

- Parametrised, handshaked successor to the single-cycle execute stage.
- Covers RV base integer ALU/branch/address ops and RV M-extension multiply/divide.
- Results are registered; divides run iteratively over multiple cycles.
- Sits between decode/regread and memory/writeback. Back-pressure is via valid/ready on both sides.

---
 rtl/execute_pkg.sv | 29 ++
 rtl/div_iter.sv | 103 ++++++++++
 rtl/execute_mc.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/execute_pkg.sv
// Shared definitions for the execute stage: RV opcodes, funct7 classes,
// branch funct3 codes and the divider state encoding.
package execute_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    typedef enum logic [1:0] {StIdle, StDiv, StFix} div_state_e;

endpackage

// File: rtl/div_iter.sv
// Iterative restoring radix-2 divider, one quotient bit per cycle.
// Ports: clk, reset_n (async active-low), flush (abort), start (load operands),
//   is_signed, ack (result taken in FIX), dividend, divisor,
//   busy (not idle), done (in FIX, result valid), quotient, remainder (sign-fixed).
module div_iter
    import execute_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            start,
    input  logic            is_signed,
    input  logic            ack,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int unsigned CNT_W = $clog2(XLEN);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic [XLEN:0]    trial;
    logic             a_neg, b_neg;

    assign a_neg = is_signed && dividend[XLEN-1];
    assign b_neg = is_signed && divisor[XLEN-1];
    // Next dividend bit is shifted out of the quotient register's MSB.
    assign trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StDiv;
                    cnt_d     = CNT_W'(XLEN - 1);
                    quo_d     = a_neg ? -dividend : dividend;
                    dvs_d     = b_neg ? -divisor : divisor;
                    rem_d     = '0;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                end
            end
            StDiv: begin
                // Borrow out of trial means restore (keep shifted remainder).
                rem_d = trial[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : trial[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], ~trial[XLEN]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = StFix;
                    cnt_d   = '0;
                end
            end
            StFix: begin
                if (ack) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign busy      = state_q != StIdle;
    assign done      = state_q == StFix;
    assign quotient  = neg_quo_q ? -quo_q : quo_q;
    assign remainder = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/execute_mc.sv
// Handshaked execute stage: RV base ALU/branch/address ops plus M-extension.
// Macro EXECUTE_MC_DIV_EN builds the iterative divider; without it divide and
// remainder ops complete in one cycle flagged illegal.
// Ports: clk, reset_n (async active-low), flush (sync kill);
//   in_valid/in_ready + in_pc, in_opcode, in_funct3, in_funct7, in_imm, in_rs1,
//   in_rs2, in_tag; out_valid/out_ready + out_res, out_br_taken, out_tag, out_illegal.
module execute_mc
    import execute_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_res,
    output logic             out_br_taken,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);
    logic              out_valid_q, out_valid_d, out_br_q, out_br_d, out_ill_q, out_ill_d;
    logic [XLEN-1:0]   out_res_q, out_res_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;
    logic              out_free, accept, div_busy, div_start;
    logic [XLEN-1:0]   c_res, op_b, add_ri, jalr_t;
    logic              c_br, c_ill, is_op, base_ill, mul_a_sgn, mul_b_sgn;
    logic [6:0]        shift_f7;
    logic [SHAMT_W-1:0] shamt;
    logic signed [XLEN-1:0] sra_s;
    logic [2*XLEN-1:0] mul_a, mul_b, prod;

    assign is_op  = in_opcode == OPC_OP;
    assign op_b   = is_op ? in_rs2 : in_imm;
    assign shamt  = op_b[SHAMT_W-1:0];
    assign sra_s  = $signed(in_rs1) >>> shamt;
    assign add_ri = in_rs1 + in_imm;
    assign jalr_t = {add_ri[XLEN-1:1], 1'b0};
    // On RV64 the shift immediate borrows funct7[0] as shamt[5].
    assign shift_f7 = (XLEN == 64) ? {in_funct7[6:1], 1'b0} : in_funct7;

    // Low 2*XLEN bits of the sign/zero-extended product are exact for all variants.
    assign mul_a_sgn = in_funct3[1:0] != 2'b11;
    assign mul_b_sgn = in_funct3[1:0] == 2'b01;
    assign mul_a = {{XLEN{mul_a_sgn & in_rs1[XLEN-1]}}, in_rs1};
    assign mul_b = {{XLEN{mul_b_sgn & in_rs2[XLEN-1]}}, in_rs2};
    assign prod  = mul_a * mul_b;

    assign base_ill = is_op ? !(in_funct7 == FUNCT7_BASE || (in_funct7 == FUNCT7_ALT &&
                                (in_funct3 == 3'd0 || in_funct3 == 3'd5)))
                            : ((in_funct3 == 3'd1 && shift_f7 != FUNCT7_BASE) ||
                               (in_funct3 == 3'd5 && shift_f7 != FUNCT7_BASE &&
                                shift_f7 != FUNCT7_ALT));

    always_comb begin
        c_res     = '0;
        c_br      = 1'b0;
        c_ill     = 1'b0;
        div_start = 1'b0;
        case (in_opcode)
            OPC_OP_IMM, OPC_OP: begin
                if (is_op && in_funct7 == FUNCT7_MULDIV) begin
                    if (!in_funct3[2]) begin
                        c_res = (in_funct3 == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                    end else begin
`ifdef EXECUTE_MC_DIV_EN
                        if (in_rs2 == '0) begin
                            c_res = in_funct3[1] ? in_rs1 : '1;
                        end else if (!in_funct3[0] && &in_rs2 &&
                                     in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) begin
                            c_res = in_funct3[1] ? '0 : in_rs1;
                        end else begin
                            div_start = 1'b1;
                        end
`else
                        c_ill = 1'b1;
`endif
                    end
                end else if (base_ill) begin
                    c_ill = 1'b1;
                end else begin
                    unique case (in_funct3)
                        3'd0: c_res = (is_op && in_funct7[5]) ? in_rs1 - op_b : in_rs1 + op_b;
                        3'd1: c_res = in_rs1 << shamt;
                        3'd2: c_res = {{(XLEN-1){1'b0}}, $signed(in_rs1) < $signed(op_b)};
                        3'd3: c_res = {{(XLEN-1){1'b0}}, in_rs1 < op_b};
                        3'd4: c_res = in_rs1 ^ op_b;
                        3'd5: c_res = in_funct7[5] ? sra_s : in_rs1 >> shamt;
                        3'd6: c_res = in_rs1 | op_b;
                        3'd7: c_res = in_rs1 & op_b;
                        default: c_res = '0;
                    endcase
                end
            end
            OPC_BRANCH: begin
                c_res = in_pc + in_imm;
                case (in_funct3)
                    F3_BEQ:  c_br = in_rs1 == in_rs2;
                    F3_BNE:  c_br = in_rs1 != in_rs2;
                    F3_BLT:  c_br = $signed(in_rs1) < $signed(in_rs2);
                    F3_BGE:  c_br = $signed(in_rs1) >= $signed(in_rs2);
                    F3_BLTU: c_br = in_rs1 < in_rs2;
                    F3_BGEU: c_br = in_rs1 >= in_rs2;
                    default: c_ill = 1'b1;
                endcase
            end
            OPC_LOAD, OPC_STORE: c_res = add_ri;
            OPC_JAL: begin
                c_res = in_pc + in_imm;
                c_br  = 1'b1;
            end
            OPC_JALR: begin
                c_res = jalr_t;
                c_br  = 1'b1;
            end
            OPC_LUI:    c_res = in_imm;
            OPC_AUIPC:  c_res = in_pc + in_imm;
            OPC_SYSTEM: c_res = '0;
            default:    c_ill = 1'b1;
        endcase
        if (c_ill) begin
            c_res = '0;
            c_br  = 1'b0;
        end
    end

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = !div_busy && out_free && !flush;
    assign accept   = in_valid && in_ready;

`ifdef EXECUTE_MC_DIV_EN
    logic             div_done, div_rem_q;
    logic [TAG_W-1:0] div_tag_q;
    logic [XLEN-1:0]  div_quo, div_rem;

    div_iter #(
        .XLEN(XLEN)
    ) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .start     (accept && div_start),
        .is_signed (!in_funct3[0]),
        .ack       (out_free),
        .dividend  (in_rs1),
        .divisor   (in_rs2),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_tag_q <= '0;
            div_rem_q <= 1'b0;
        end else if (accept && div_start) begin
            div_tag_q <= in_tag;
            div_rem_q <= in_funct3[1];
        end
    end
`else
    assign div_busy = 1'b0;
`endif

    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        out_res_d   = out_res_q;
        out_br_d    = out_br_q;
        out_tag_d   = out_tag_q;
        out_ill_d   = out_ill_q;
        if (accept && !div_start) begin
            out_valid_d = 1'b1;
            out_res_d   = c_res;
            out_br_d    = c_br;
            out_tag_d   = in_tag;
            out_ill_d   = c_ill;
        end
`ifdef EXECUTE_MC_DIV_EN
        else if (div_done && out_free) begin
            out_valid_d = 1'b1;
            out_res_d   = div_rem_q ? div_rem : div_quo;
            out_br_d    = 1'b0;
            out_tag_d   = div_tag_q;
            out_ill_d   = 1'b0;
        end
`endif
        if (flush) out_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_br_q    <= 1'b0;
            out_tag_q   <= '0;
            out_ill_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_br_q    <= out_br_d;
            out_tag_q   <= out_tag_d;
            out_ill_q   <= out_ill_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_res      = out_res_q;
    assign out_br_taken = out_br_q;
    assign out_tag      = out_tag_q;
    assign out_illegal  = out_ill_q;

endmodule
